// File: rtl/sdram_cmd_arbiter_if.sv
// rtl/sdram_cmd_arbiter_if.sv - requester and SDRAM controller signals for sdram_cmd_arbiter
// master is the arbiter side; slave is the requesters plus SDRAM controller.
interface sdram_cmd_arbiter_if #(
   parameter int AddrWidth = 23,
   parameter int DataWidth = 16
);
   logic                 req0_trigger;
   logic                 req0_write;
   logic [AddrWidth-1:0] req0_addr;
   logic [DataWidth-1:0] req0_wdata;
   logic                 req0_accept;
   logic [DataWidth-1:0] req0_rdata;
   logic                 req0_rvalid;

   logic                 req1_trigger;
   logic                 req1_write;
   logic [AddrWidth-1:0] req1_addr;
   logic [DataWidth-1:0] req1_wdata;
   logic                 req1_accept;
   logic [DataWidth-1:0] req1_rdata;
   logic                 req1_rvalid;

   logic                 cmdTrigger;
   logic                 cmdWrite;
   logic [AddrWidth-1:0] cmdAddr;
   logic [DataWidth-1:0] cmdWriteData;
   logic                 cmdReady;
   logic [DataWidth-1:0] cmdReadData;
   logic                 cmdReadDataValid;

   logic                 tagError;

   modport master (
      input  req0_trigger, req0_write, req0_addr, req0_wdata,
      input  req1_trigger, req1_write, req1_addr, req1_wdata,
      input  cmdReady, cmdReadData, cmdReadDataValid,
      output req0_accept, req0_rdata, req0_rvalid,
      output req1_accept, req1_rdata, req1_rvalid,
      output cmdTrigger, cmdWrite, cmdAddr, cmdWriteData,
      output tagError
   );

   modport slave (
      output req0_trigger, req0_write, req0_addr, req0_wdata,
      output req1_trigger, req1_write, req1_addr, req1_wdata,
      output cmdReady, cmdReadData, cmdReadDataValid,
      input  req0_accept, req0_rdata, req0_rvalid,
      input  req1_accept, req1_rdata, req1_rvalid,
      input  cmdTrigger, cmdWrite, cmdAddr, cmdWriteData,
      input  tagError
   );
endinterface

// File: rtl/sdram_cmd_arbiter.sv
// rtl/sdram_cmd_arbiter.sv - two-port round-robin SDRAM command arbiter with read tag FIFO
// Read data is routed back to its requester through an in-order FIFO of grant indices.
module sdram_cmd_arbiter #(
   parameter int AddrWidth = 23,
   parameter int DataWidth = 16,
   parameter int TagDepth  = 4
) (
   input  logic                clk12mhz,
   input  logic                rst,
   sdram_cmd_arbiter_if.master bus
);
   localparam int PtrW = $clog2(TagDepth);
   localparam int CntW = PtrW + 1;

   typedef enum logic {IDLE, ISSUE} state_e;

   state_e               state_q, state_d;
   logic                 grant_q, grant_d;
   logic                 last_q, last_d;
   logic                 cmd_trigger_q, cmd_trigger_d;
   logic                 cmd_write_q, cmd_write_d;
   logic [AddrWidth-1:0] cmd_addr_q, cmd_addr_d;
   logic [DataWidth-1:0] cmd_wdata_q, cmd_wdata_d;
   logic [TagDepth-1:0]  tag_mem_q, tag_mem_d;
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]      count_q, count_d;
   logic [DataWidth-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic                 rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic                 tag_error_q, tag_error_d;

   logic fifo_full, fifo_empty, elig0, elig1, pick, cmd_fire, push, pop, head_tag;

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_d        = last_q;
      cmd_trigger_d = cmd_trigger_q;
      cmd_write_d   = cmd_write_q;
      cmd_addr_d    = cmd_addr_q;
      cmd_wdata_d   = cmd_wdata_q;
      tag_mem_d     = tag_mem_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      rdata0_d      = rdata0_q;
      rdata1_d      = rdata1_q;
      rvalid0_d     = 1'b0;
      rvalid1_d     = 1'b0;
      pick          = 1'b0;

      // Eligibility uses the registered count, so a pop only frees space for the next cycle.
      fifo_full  = (count_q == CntW'(TagDepth));
      fifo_empty = (count_q == '0);
      elig0      = bus.req0_trigger && (bus.req0_write || !fifo_full);
      elig1      = bus.req1_trigger && (bus.req1_write || !fifo_full);
      cmd_fire   = (state_q == ISSUE) && cmd_trigger_q && bus.cmdReady;
      push       = cmd_fire && !cmd_write_q;
      pop        = bus.cmdReadDataValid && !fifo_empty;
      head_tag   = tag_mem_q[rd_ptr_q];

      case (state_q)
         IDLE: begin
            if (elig0 || elig1) begin
               pick          = (elig0 && elig1) ? ~last_q : elig1;
               grant_d       = pick;
               last_d        = pick;
               cmd_trigger_d = 1'b1;
               cmd_write_d   = pick ? bus.req1_write : bus.req0_write;
               cmd_addr_d    = pick ? bus.req1_addr  : bus.req0_addr;
               cmd_wdata_d   = pick ? bus.req1_wdata : bus.req0_wdata;
               state_d       = ISSUE;
            end
         end
         ISSUE: begin
            if (cmd_fire) begin
               cmd_trigger_d = 1'b0;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (push) begin
         tag_mem_d[wr_ptr_q] = grant_q;
         wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         if (head_tag) begin
            rdata1_d  = bus.cmdReadData;
            rvalid1_d = 1'b1;
         end else begin
            rdata0_d  = bus.cmdReadData;
            rvalid0_d = 1'b1;
         end
      end
      count_d     = count_q + CntW'(push) - CntW'(pop);
      tag_error_d = tag_error_q || (bus.cmdReadDataValid && fifo_empty);
   end

   always_ff @(posedge clk12mhz) begin
      if (rst) begin
         state_q       <= IDLE;
         grant_q       <= 1'b0;
         last_q        <= 1'b1;
         cmd_trigger_q <= 1'b0;
         cmd_write_q   <= 1'b0;
         cmd_addr_q    <= '0;
         cmd_wdata_q   <= '0;
         tag_mem_q     <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         rdata0_q      <= '0;
         rdata1_q      <= '0;
         rvalid0_q     <= 1'b0;
         rvalid1_q     <= 1'b0;
         tag_error_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_q        <= last_d;
         cmd_trigger_q <= cmd_trigger_d;
         cmd_write_q   <= cmd_write_d;
         cmd_addr_q    <= cmd_addr_d;
         cmd_wdata_q   <= cmd_wdata_d;
         tag_mem_q     <= tag_mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         rdata0_q      <= rdata0_d;
         rdata1_q      <= rdata1_d;
         rvalid0_q     <= rvalid0_d;
         rvalid1_q     <= rvalid1_d;
         tag_error_q   <= tag_error_d;
      end
   end

   assign bus.req0_accept  = cmd_fire && !rst && !grant_q;
   assign bus.req1_accept  = cmd_fire && !rst && grant_q;
   assign bus.req0_rdata   = rdata0_q;
   assign bus.req1_rdata   = rdata1_q;
   assign bus.req0_rvalid  = rvalid0_q;
   assign bus.req1_rvalid  = rvalid1_q;
   assign bus.cmdTrigger   = cmd_trigger_q;
   assign bus.cmdWrite     = cmd_write_q;
   assign bus.cmdAddr      = cmd_addr_q;
   assign bus.cmdWriteData = cmd_wdata_q;
   assign bus.tagError     = tag_error_q;
endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// tb/tb_sdram_cmd_arbiter.sv - directed self-checking bench for sdram_cmd_arbiter
// Inputs change and outputs are sampled around the falling edge of clk.
module tb_sdram_cmd_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   sdram_cmd_arbiter_if #(.AddrWidth(23), .DataWidth(16)) bus ();

   sdram_cmd_arbiter #(.AddrWidth(23), .DataWidth(16), .TagDepth(4)) dut (
      .clk12mhz (clk),
      .rst      (rst),
      .bus      (bus.master)
   );

   task automatic idle_inputs();
      bus.req0_trigger = 0; bus.req0_write = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
      bus.req1_trigger = 0; bus.req1_write = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
      bus.cmdReady = 0; bus.cmdReadData = '0; bus.cmdReadDataValid = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      bus.cmdReady = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (bus.cmdTrigger !== 1'b0) begin n_fail++; $display("FAIL rst_trigger got %0b want 0", bus.cmdTrigger); end
      n_checks++; if (bus.cmdWrite !== 1'b0) begin n_fail++; $display("FAIL rst_write got %0b want 0", bus.cmdWrite); end
      n_checks++; if (bus.cmdAddr !== 23'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", bus.cmdAddr); end
      n_checks++; if (bus.cmdWriteData !== 16'h0) begin n_fail++; $display("FAIL rst_wdata got %h want 0", bus.cmdWriteData); end
      n_checks++; if ({bus.req0_rvalid, bus.req1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid got %b want 00", {bus.req0_rvalid, bus.req1_rvalid}); end
      n_checks++; if ({bus.req0_rdata, bus.req1_rdata} !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", {bus.req0_rdata, bus.req1_rdata}); end
      n_checks++; if (bus.tagError !== 1'b0) begin n_fail++; $display("FAIL rst_tagerror got %0b want 0", bus.tagError); end
      n_checks++; if ({bus.req0_accept, bus.req1_accept} !== 2'b00) begin n_fail++; $display("FAIL rst_accept got %b want 00", {bus.req0_accept, bus.req1_accept}); end
      rst = 1'b0;
      bus.cmdReady = 1'b0;
   endtask

   task automatic test_write_stall();
      do_reset();
      @(negedge clk);
      bus.req0_trigger = 1; bus.req0_write = 1; bus.req0_addr = 23'h000123; bus.req0_wdata = 16'hBEEF;
      bus.cmdReady = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i == 3) bus.req0_trigger = 0;
         #1;
         n_checks++; if (bus.cmdTrigger !== 1'b1) begin n_fail++; $display("FAIL wr_hold_trigger c%0d got %0b want 1", i, bus.cmdTrigger); end
         n_checks++; if (bus.cmdAddr !== 23'h000123) begin n_fail++; $display("FAIL wr_hold_addr c%0d got %h want 000123", i, bus.cmdAddr); end
         n_checks++; if (bus.cmdWriteData !== 16'hBEEF) begin n_fail++; $display("FAIL wr_hold_wdata c%0d got %h want beef", i, bus.cmdWriteData); end
         n_checks++; if (bus.req0_accept !== 1'b0) begin n_fail++; $display("FAIL wr_hold_accept c%0d got %0b want 0", i, bus.req0_accept); end
      end
      @(negedge clk);
      bus.cmdReady = 1;
      #1;
      n_checks++; if ({bus.req0_accept, bus.req1_accept} !== 2'b10) begin n_fail++; $display("FAIL wr_accept got %b want 10", {bus.req0_accept, bus.req1_accept}); end
      n_checks++; if (bus.cmdWrite !== 1'b1) begin n_fail++; $display("FAIL wr_cmdwrite got %0b want 1", bus.cmdWrite); end
      n_checks++; if (bus.cmdAddr !== 23'h000123) begin n_fail++; $display("FAIL wr_addr got %h want 000123", bus.cmdAddr); end
      @(negedge clk);
      #1;
      n_checks++; if (bus.cmdTrigger !== 1'b0) begin n_fail++; $display("FAIL wr_after_trigger got %0b want 0", bus.cmdTrigger); end
      n_checks++; if (bus.req0_accept !== 1'b0) begin n_fail++; $display("FAIL wr_after_accept got %0b want 0", bus.req0_accept); end
   endtask

   task automatic test_rr_reads();
      do_reset();
      bus.cmdReady = 1;
      @(negedge clk);
      bus.req0_trigger = 1; bus.req0_write = 0; bus.req0_addr = 23'h10;
      bus.req1_trigger = 1; bus.req1_write = 0; bus.req1_addr = 23'h20;
      @(negedge clk); #1;
      n_checks++; if ({bus.req0_accept, bus.req1_accept} !== 2'b10) begin n_fail++; $display("FAIL rr_first_accept got %b want 10", {bus.req0_accept, bus.req1_accept}); end
      n_checks++; if (bus.cmdAddr !== 23'h10) begin n_fail++; $display("FAIL rr_first_addr got %h want 10", bus.cmdAddr); end
      bus.req0_trigger = 0;
      @(negedge clk); #1;
      n_checks++; if ({bus.req0_accept, bus.req1_accept} !== 2'b00) begin n_fail++; $display("FAIL rr_gap_accept got %b want 00", {bus.req0_accept, bus.req1_accept}); end
      @(negedge clk); #1;
      n_checks++; if ({bus.req0_accept, bus.req1_accept} !== 2'b01) begin n_fail++; $display("FAIL rr_second_accept got %b want 01", {bus.req0_accept, bus.req1_accept}); end
      n_checks++; if (bus.cmdAddr !== 23'h20) begin n_fail++; $display("FAIL rr_second_addr got %h want 20", bus.cmdAddr); end
      bus.req1_trigger = 0;
      @(negedge clk);
      bus.cmdReadDataValid = 1; bus.cmdReadData = 16'h1111;
      @(negedge clk);
      bus.cmdReadDataValid = 1; bus.cmdReadData = 16'h2222;
      #1;
      n_checks++; if ({bus.req0_rvalid, bus.req1_rvalid} !== 2'b10) begin n_fail++; $display("FAIL rr_rvalid0 got %b want 10", {bus.req0_rvalid, bus.req1_rvalid}); end
      n_checks++; if (bus.req0_rdata !== 16'h1111) begin n_fail++; $display("FAIL rr_rdata0 got %h want 1111", bus.req0_rdata); end
      @(negedge clk);
      bus.cmdReadDataValid = 0;
      #1;
      n_checks++; if ({bus.req0_rvalid, bus.req1_rvalid} !== 2'b01) begin n_fail++; $display("FAIL rr_rvalid1 got %b want 01", {bus.req0_rvalid, bus.req1_rvalid}); end
      n_checks++; if (bus.req1_rdata !== 16'h2222) begin n_fail++; $display("FAIL rr_rdata1 got %h want 2222", bus.req1_rdata); end
      @(negedge clk); #1;
      n_checks++; if ({bus.req0_rvalid, bus.req1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rr_rvalid_end got %b want 00", {bus.req0_rvalid, bus.req1_rvalid}); end
   endtask

   task automatic test_fifo_full();
      do_reset();
      bus.cmdReady = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.req1_trigger = 1; bus.req1_write = 0; bus.req1_addr = 23'h100 + 23'(k);
         @(negedge clk); #1;
         n_checks++; if (bus.req1_accept !== 1'b1) begin n_fail++; $display("FAIL full_fill_accept k%0d got %0b want 1", k, bus.req1_accept); end
         bus.req1_trigger = 0;
      end
      @(negedge clk);
      bus.req1_trigger = 1; bus.req1_write = 0; bus.req1_addr = 23'h200;
      bus.req0_trigger = 1; bus.req0_write = 1; bus.req0_addr = 23'h300; bus.req0_wdata = 16'h1234;
      @(negedge clk); #1;
      n_checks++; if ({bus.req0_accept, bus.req1_accept} !== 2'b10) begin n_fail++; $display("FAIL full_write_accept got %b want 10", {bus.req0_accept, bus.req1_accept}); end
      n_checks++; if (bus.cmdWrite !== 1'b1) begin n_fail++; $display("FAIL full_write_cmdwrite got %0b want 1", bus.cmdWrite); end
      n_checks++; if (bus.cmdAddr !== 23'h300) begin n_fail++; $display("FAIL full_write_addr got %h want 300", bus.cmdAddr); end
      bus.req0_trigger = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         n_checks++; if (bus.cmdTrigger !== 1'b0) begin n_fail++; $display("FAIL full_read_stall c%0d got %0b want 0", i, bus.cmdTrigger); end
      end
      bus.cmdReadDataValid = 1; bus.cmdReadData = 16'hAAAA;
      @(negedge clk);
      bus.cmdReadDataValid = 0;
      #1;
      n_checks++; if ({bus.req0_rvalid, bus.req1_rvalid} !== 2'b01) begin n_fail++; $display("FAIL full_pop_rvalid got %b want 01", {bus.req0_rvalid, bus.req1_rvalid}); end
      n_checks++; if (bus.req1_rdata !== 16'hAAAA) begin n_fail++; $display("FAIL full_pop_rdata got %h want aaaa", bus.req1_rdata); end
      n_checks++; if (bus.cmdTrigger !== 1'b0) begin n_fail++; $display("FAIL full_pop_same_cycle got %0b want 0", bus.cmdTrigger); end
      @(negedge clk); #1;
      n_checks++; if (bus.req1_accept !== 1'b1) begin n_fail++; $display("FAIL full_late_accept got %0b want 1", bus.req1_accept); end
      n_checks++; if (bus.cmdWrite !== 1'b0) begin n_fail++; $display("FAIL full_late_cmdwrite got %0b want 0", bus.cmdWrite); end
      n_checks++; if (bus.cmdAddr !== 23'h200) begin n_fail++; $display("FAIL full_late_addr got %h want 200", bus.cmdAddr); end
      bus.req1_trigger = 0;
   endtask

   task automatic test_push_pop();
      do_reset();
      bus.cmdReady = 1;
      @(negedge clk);
      bus.req0_trigger = 1; bus.req0_write = 0; bus.req0_addr = 23'h40;
      @(negedge clk); #1;
      n_checks++; if (bus.req0_accept !== 1'b1) begin n_fail++; $display("FAIL pp_accept0 got %0b want 1", bus.req0_accept); end
      bus.req0_trigger = 0;
      @(negedge clk);
      bus.req1_trigger = 1; bus.req1_write = 0; bus.req1_addr = 23'h50;
      @(negedge clk); #1;
      n_checks++; if (bus.req1_accept !== 1'b1) begin n_fail++; $display("FAIL pp_accept1 got %0b want 1", bus.req1_accept); end
      bus.req1_trigger = 0;
      bus.cmdReadDataValid = 1; bus.cmdReadData = 16'h5555;
      @(negedge clk);
      bus.cmdReadData = 16'h6666;
      #1;
      n_checks++; if ({bus.req0_rvalid, bus.req1_rvalid} !== 2'b10) begin n_fail++; $display("FAIL pp_old_tag_rvalid got %b want 10", {bus.req0_rvalid, bus.req1_rvalid}); end
      n_checks++; if (bus.req0_rdata !== 16'h5555) begin n_fail++; $display("FAIL pp_old_tag_rdata got %h want 5555", bus.req0_rdata); end
      @(negedge clk);
      bus.cmdReadData = 16'h7777;
      #1;
      n_checks++; if ({bus.req0_rvalid, bus.req1_rvalid} !== 2'b01) begin n_fail++; $display("FAIL pp_new_tag_rvalid got %b want 01", {bus.req0_rvalid, bus.req1_rvalid}); end
      n_checks++; if (bus.req1_rdata !== 16'h6666) begin n_fail++; $display("FAIL pp_new_tag_rdata got %h want 6666", bus.req1_rdata); end
      n_checks++; if (bus.tagError !== 1'b0) begin n_fail++; $display("FAIL pp_no_tagerror got %0b want 0", bus.tagError); end
      @(negedge clk);
      bus.cmdReadDataValid = 0;
      #1;
      n_checks++; if ({bus.req0_rvalid, bus.req1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL pp_extra_rvalid got %b want 00", {bus.req0_rvalid, bus.req1_rvalid}); end
      n_checks++; if (bus.tagError !== 1'b1) begin n_fail++; $display("FAIL pp_extra_tagerror got %0b want 1", bus.tagError); end
   endtask

   task automatic test_tag_error();
      do_reset();
      @(negedge clk);
      bus.cmdReadDataValid = 1; bus.cmdReadData = 16'h9999;
      @(negedge clk);
      bus.cmdReadDataValid = 0;
      #1;
      n_checks++; if ({bus.req0_rvalid, bus.req1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL te_rvalid got %b want 00", {bus.req0_rvalid, bus.req1_rvalid}); end
      n_checks++; if (bus.tagError !== 1'b1) begin n_fail++; $display("FAIL te_set got %0b want 1", bus.tagError); end
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (bus.tagError !== 1'b1) begin n_fail++; $display("FAIL te_sticky got %0b want 1", bus.tagError); end
      rst = 1'b1;
      @(negedge clk); #1;
      n_checks++; if (bus.tagError !== 1'b0) begin n_fail++; $display("FAIL te_cleared got %0b want 0", bus.tagError); end
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_issue();
      do_reset();
      bus.cmdReady = 1;
      @(negedge clk);
      bus.req0_trigger = 1; bus.req0_write = 0; bus.req0_addr = 23'h60;
      bus.req1_trigger = 1; bus.req1_write = 0; bus.req1_addr = 23'h70;
      @(negedge clk); #1;
      n_checks++; if (bus.req0_accept !== 1'b1) begin n_fail++; $display("FAIL rmi_accept0 got %0b want 1", bus.req0_accept); end
      bus.req0_trigger = 0;
      @(negedge clk);
      @(negedge clk); #1;
      n_checks++; if (bus.req1_accept !== 1'b1) begin n_fail++; $display("FAIL rmi_accept1 got %0b want 1", bus.req1_accept); end
      bus.req1_trigger = 0;
      bus.cmdReady = 0;
      @(negedge clk);
      bus.req0_trigger = 1; bus.req0_write = 1; bus.req0_addr = 23'h80; bus.req0_wdata = 16'h0F0F;
      @(negedge clk); #1;
      n_checks++; if (bus.cmdTrigger !== 1'b1) begin n_fail++; $display("FAIL rmi_trigger_before got %0b want 1", bus.cmdTrigger); end
      rst = 1'b1;
      bus.cmdReady = 1;
      bus.req0_trigger = 0;
      #1;
      n_checks++; if (bus.req0_accept !== 1'b0) begin n_fail++; $display("FAIL rmi_accept_in_reset got %0b want 0", bus.req0_accept); end
      @(negedge clk); #1;
      n_checks++; if (bus.cmdTrigger !== 1'b0) begin n_fail++; $display("FAIL rmi_trigger_after got %0b want 0", bus.cmdTrigger); end
      rst = 1'b0;
      bus.cmdReady = 0;
      @(negedge clk);
      bus.cmdReadDataValid = 1; bus.cmdReadData = 16'hCCCC;
      @(negedge clk);
      bus.cmdReadDataValid = 0;
      #1;
      n_checks++; if (bus.tagError !== 1'b1) begin n_fail++; $display("FAIL rmi_tagerror got %0b want 1", bus.tagError); end
      n_checks++; if ({bus.req0_rvalid, bus.req1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rmi_rvalid got %b want 00", {bus.req0_rvalid, bus.req1_rvalid}); end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_write_stall();
      test_rr_reads();
      test_fifo_full();
      test_push_pop();
      test_tag_error();
      test_reset_mid_issue();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout after %0d checks", n_checks);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/sdram_cmd_arbiter.md
SDRAM_CMD_ARBITER -- requirements
Module: sdram_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 23, meaning SDRAM word address width.
REQ-002 The block SHALL have parameter DataWidth, default 16, meaning SDRAM word width.
REQ-003 The block SHALL have parameter TagDepth, default 4 (power of 2), meaning outstanding-read tag FIFO depth.
REQ-004 The block SHALL have port clk12mhz  in  1  system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 For N in {0,1}, the block SHALL have ports reqN_trigger in 1, reqN_write in 1, reqN_addr in AddrWidth, reqN_wdata in DataWidth, meaning requester N command, held stable until accepted.
REQ-007 For N in {0,1}, the block SHALL have port reqN_accept  out  1  meaning requester N command taken by the controller this cycle.
REQ-008 For N in {0,1}, the block SHALL have ports reqN_rdata out DataWidth and reqN_rvalid out 1, meaning read data returned to requester N.
REQ-009 The block SHALL have ports cmdTrigger out 1, cmdWrite out 1, cmdAddr out AddrWidth, cmdWriteData out DataWidth, meaning the command to the SDRAM controller.
REQ-010 The block SHALL have ports cmdReady in 1, cmdReadData in DataWidth, cmdReadDataValid in 1, meaning the SDRAM controller response.
REQ-011 The block SHALL have port tagError  out  1  meaning sticky flag: read data arrived with no outstanding tag.

Function
REQ-012 The controller SHALL accept a command in any cycle with cmdTrigger && cmdReady.
REQ-013 The FSM SHALL have two states, IDLE and ISSUE.
REQ-014 IDLE: a requester is eligible if reqN_trigger is high and (reqN_write, or tag FIFO not full).
REQ-015 IDLE, one eligible requester: grant it; two eligible: grant the port not granted last (round-robin); after reset port 0 wins the first tie.
REQ-016 On grant, the block SHALL register write/addr/wdata of the granted port into cmd*, set cmdTrigger=1 on the next cycle, record the grant index, and enter ISSUE.
REQ-017 ISSUE: cmdTrigger and cmd* SHALL be held constant until cmdReady.
REQ-018 In the cycle cmdTrigger && cmdReady, reqN_accept SHALL be high combinationally for the granted port only.
REQ-019 In that same cycle, if the command is a read, the grant index SHALL be pushed into the tag FIFO; on the next edge cmdTrigger=0 and the FSM returns to IDLE.
REQ-020 Grant-to-accept minimum latency SHALL be 1 cycle: request seen in IDLE at cycle T, cmdTrigger high at T+1, accept at T+1 if cmdReady.
REQ-021 Back-to-back commands SHALL have a minimum spacing of 2 cycles (one IDLE cycle between accepts).
REQ-022 A requester SHALL drop reqN_trigger on the edge it samples reqN_accept, so the following IDLE cycle sees no stale request.
REQ-023 On cmdReadDataValid, the block SHALL pop the FIFO head tag t.
REQ-024 On the same edge as the pop, the block SHALL register reqt_rdata=cmdReadData and set reqt_rvalid=1 for exactly 1 cycle; the other port's rvalid stays 0.
REQ-025 Read return latency SHALL be 1 cycle after cmdReadDataValid; read data order SHALL be the same as read accept order.
REQ-026 A push and a pop in the same cycle SHALL leave the FIFO count unchanged, with both operations taking effect.
REQ-027 The count width SHALL be log2(TagDepth)+1 bits; read/write pointers SHALL wrap modulo TagDepth.
REQ-028 When the FIFO is full, read requests SHALL stay ungranted and write requests SHALL be granted normally.
REQ-029 A pop that frees space SHALL make a read eligible no earlier than the following cycle.
REQ-030 cmdReadDataValid with an empty FIFO SHALL be dropped: no rvalid, tagError set to 1 until reset.
REQ-031 A requester dropping reqN_trigger while in ISSUE SHALL NOT abort the command; it still completes, and accept still pulses.

Reset
REQ-032 While rst is high, the block SHALL force state=IDLE, cmdTrigger=0, cmdWrite=0, cmdAddr=0, cmdWriteData=0, req0_rvalid=req1_rvalid=0, reqN_rdata=0, tagError=0, FIFO empty, round-robin pointer favoring port 0.
REQ-033 Reset asserted mid-ISSUE SHALL drop cmdTrigger at the next edge, and outstanding tags SHALL be discarded.
REQ-034 reqN_accept SHALL be 0 during reset.

Verification
REQ-035 The bench SHALL cover: reset, then req0 writes addr 0x000123 data 0xBEEF with cmdReady held 0 for 5 cycles -> cmdTrigger high and constant for the 5 cycles, req0_accept one pulse when cmdReady=1, cmdAddr=0x000123, cmdWriteData=0xBEEF.
REQ-036 The bench SHALL cover: both ports trigger reads in the same cycle, controller always ready -> grants 0 then 1, accepts 2 cycles apart; two cmdReadDataValid (0x1111, 0x2222) -> req0_rvalid with 0x1111, then req1_rvalid with 0x2222.
REQ-037 The bench SHALL cover: req1 issues 4 reads with no data returned, then req1 read plus req0 write pending -> req0 write granted, req1 read stalls; one cmdReadDataValid -> req1 granted on a later cycle.
REQ-038 The bench SHALL cover: FIFO holding 1 tag, a read accepted in the same cycle as cmdReadDataValid -> count stays 1, and data goes to the older tag's port.
REQ-039 The bench SHALL cover: cmdReadDataValid with an empty FIFO -> no rvalid, tagError=1 until rst.
REQ-040 The bench SHALL cover: rst pulsed while cmdTrigger=1 with 2 tags outstanding -> cmdTrigger=0 next cycle, a later cmdReadDataValid sets tagError.
